// File: rtl/rice_pkg.sv
// rice_pkg: shared decoder state type, Rice constants and the zigzag unfold helper.
package rice_pkg;

    localparam int         WORD_W      = 16;
    localparam int         FILL_W      = 5;
    localparam logic [3:0] RICE_ESCAPE = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNARY,
        ST_BINARY,
        ST_EMIT,
        ST_ERROR,
        ST_ESC_WIDTH,
        ST_ESC_RAW
    } dec_state_t;

    // Folded unsigned u back to signed: even u -> u/2, odd u -> -(u/2)-1 (which is ~(u/2)).
    function automatic logic [15:0] zigzagUnfold(input logic [16:0] u);
        return u[0] ? ~u[16:1] : u[16:1];
    endfunction

endpackage

// File: rtl/rice_bit_buffer.sv
// rice_bit_buffer: one-word MSB-first bit buffer feeding the Rice decoder FSM a bit per cycle.
module rice_bit_buffer
    import rice_pkg::*;
(
    input  logic              iClock,
    input  logic              iResetN,
    input  logic              iFlush,
    input  logic              iWant,
    input  logic [WORD_W-1:0] iData,
    input  logic              iDataValid,
    output logic              oDataReady,
    output logic              oBit,
    output logic              oBitValid
);

    logic [WORD_W-1:0] r_shift;
    logic [FILL_W-1:0] r_fill;
    logic              w_load;

    assign oDataReady = iWant && (r_fill == '0);
    assign w_load     = oDataReady && iDataValid;
    assign oBitValid  = iWant && (r_fill != '0);
    assign oBit       = r_shift[WORD_W-1];

    // Flush wins over load and pop; load and pop never coincide since a load needs an empty buffer.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (iFlush) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (w_load) begin
            r_shift <= iData;
            r_fill  <= FILL_W'(WORD_W);
        end else if (oBitValid) begin
            r_shift <= r_shift << 1;
            r_fill  <= r_fill - 1'b1;
        end
    end

endmodule

// File: rtl/rice_residual_decoder.sv
// rice_residual_decoder: decodes a partition of Rice-coded FLAC residuals from a 16-bit word stream.
// Optional FLAC escape-code support (k=15, raw n-bit residuals) is enabled by defining RICE_ESCAPE_EN.
module rice_residual_decoder
    import rice_pkg::*;
#(
    parameter int MAX_QUOTIENT = 4095
) (
    input  logic        iClock,
    input  logic        iResetN,
    input  logic        iStart,
    input  logic [15:0] iNSamples,
    input  logic [3:0]  iRiceParam,
    input  logic [15:0] iData,
    input  logic        iDataValid,
    output logic        oDataReady,
    output logic [15:0] oResidual,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oTotalBits,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError
);

    localparam logic [15:0] MAX_Q = 16'(MAX_QUOTIENT);

    dec_state_t  r_state, w_stateNext;
    logic [15:0] r_q, w_qNext;
    logic [15:0] r_rem, w_remNext;
    logic [4:0]  r_bitCnt, w_bitCntNext;
    logic [15:0] r_count, w_countNext;
    logic [15:0] r_n, w_nNext;
    logic [3:0]  r_k, w_kNext;
    logic [15:0] r_residual, w_residualNext;
    logic [31:0] r_totalBits, w_totalBitsNext;
    logic        r_done, w_doneNext;

    logic        w_flush;
    logic        w_want;
    logic        w_bit;
    logic        w_bitValid;
    logic [15:0] w_shiftIn;
    logic [15:0] w_countInc;
    logic [31:0] w_uUnary;
    logic [31:0] w_uBinary;
    logic [31:0] w_uFinal;
    logic        w_uOverflow;
    logic [15:0] w_uResidual;

`ifdef RICE_ESCAPE_EN
    logic [4:0]  r_escWidth, w_escWidthNext;
    logic        w_signBit;
    logic [15:0] w_rawValue;
`endif

    assign w_want = (r_state == ST_UNARY) || (r_state == ST_BINARY) ||
                    (r_state == ST_ESC_WIDTH) || (r_state == ST_ESC_RAW);

    rice_bit_buffer u_buffer (
        .iClock     (iClock),
        .iResetN    (iResetN),
        .iFlush     (w_flush),
        .iWant      (w_want),
        .iData      (iData),
        .iDataValid (iDataValid),
        .oDataReady (oDataReady),
        .oBit       (w_bit),
        .oBitValid  (w_bitValid)
    );

    assign w_shiftIn   = (r_rem << 1) | {15'b0, w_bit};
    assign w_countInc  = r_count + 16'd1;
    assign w_uUnary    = {16'b0, r_q};
    assign w_uBinary   = ({16'b0, r_q} << r_k) | {16'b0, w_shiftIn};
    assign w_uFinal    = (r_state == ST_UNARY) ? w_uUnary : w_uBinary;
    assign w_uOverflow = |w_uFinal[31:16];
    assign w_uResidual = zigzagUnfold(w_uFinal[16:0]);

`ifdef RICE_ESCAPE_EN
    assign w_signBit  = |(w_shiftIn & (16'h0001 << (r_escWidth - 5'd1)));
    assign w_rawValue = w_signBit ? (w_shiftIn | (16'hFFFF << r_escWidth)) : w_shiftIn;
`endif

    assign oValid     = (r_state == ST_EMIT);
    assign oBusy      = (r_state != ST_IDLE) && (r_state != ST_ERROR);
    assign oError     = (r_state == ST_ERROR);
    assign oDone      = r_done;
    assign oResidual  = r_residual;
    assign oTotalBits = r_totalBits;

    // Next-state and datapath updates: one bit per cycle in the reading states, residual hold in EMIT.
    always_comb begin
        w_stateNext     = r_state;
        w_qNext         = r_q;
        w_remNext       = r_rem;
        w_bitCntNext    = r_bitCnt;
        w_countNext     = r_count;
        w_nNext         = r_n;
        w_kNext         = r_k;
        w_residualNext  = r_residual;
        w_totalBitsNext = r_totalBits + {31'b0, w_bitValid};
        w_doneNext      = 1'b0;
        w_flush         = 1'b0;
`ifdef RICE_ESCAPE_EN
        w_escWidthNext  = r_escWidth;
`endif

        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (iStart) begin
                    w_flush         = (r_state == ST_ERROR);
                    w_totalBitsNext = '0;
                    w_nNext         = iNSamples;
                    w_kNext         = iRiceParam;
                    w_countNext     = '0;
                    w_qNext         = '0;
                    w_remNext       = '0;
`ifdef RICE_ESCAPE_EN
                    if (iNSamples == '0) begin
                        w_doneNext  = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else if (iRiceParam == RICE_ESCAPE) begin
                        w_bitCntNext = 5'd5;
                        w_stateNext  = ST_ESC_WIDTH;
                    end else begin
                        w_stateNext = ST_UNARY;
                    end
`else
                    if (iRiceParam == RICE_ESCAPE) begin
                        w_stateNext = ST_ERROR;
                    end else if (iNSamples == '0) begin
                        w_doneNext  = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_stateNext = ST_UNARY;
                    end
`endif
                end
            end

            ST_UNARY: begin
                if (w_bitValid) begin
                    if (w_bit) begin
                        if (r_k == '0) begin
                            if (w_uOverflow) begin
                                w_stateNext = ST_ERROR;
                            end else begin
                                w_residualNext = w_uResidual;
                                w_stateNext    = ST_EMIT;
                            end
                        end else begin
                            w_remNext    = '0;
                            w_bitCntNext = {1'b0, r_k};
                            w_stateNext  = ST_BINARY;
                        end
                    end else if (r_q == MAX_Q) begin
                        w_stateNext = ST_ERROR;
                    end else begin
                        w_qNext = r_q + 16'd1;
                    end
                end
            end

            ST_BINARY: begin
                if (w_bitValid) begin
                    w_remNext    = w_shiftIn;
                    w_bitCntNext = r_bitCnt - 5'd1;
                    if (r_bitCnt == 5'd1) begin
                        if (w_uOverflow) begin
                            w_stateNext = ST_ERROR;
                        end else begin
                            w_residualNext = w_uResidual;
                            w_stateNext    = ST_EMIT;
                        end
                    end
                end
            end

            ST_EMIT: begin
                if (iReady) begin
                    w_countNext = w_countInc;
                    if (w_countInc == r_n) begin
                        w_doneNext  = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_qNext   = '0;
                        w_remNext = '0;
`ifdef RICE_ESCAPE_EN
                        if (r_k == RICE_ESCAPE) begin
                            if (r_escWidth == '0) begin
                                w_residualNext = '0;
                                w_stateNext    = ST_EMIT;
                            end else begin
                                w_bitCntNext = r_escWidth;
                                w_stateNext  = ST_ESC_RAW;
                            end
                        end else begin
                            w_stateNext = ST_UNARY;
                        end
`else
                        w_stateNext = ST_UNARY;
`endif
                    end
                end
            end

`ifdef RICE_ESCAPE_EN
            ST_ESC_WIDTH: begin
                if (w_bitValid) begin
                    w_remNext    = w_shiftIn;
                    w_bitCntNext = r_bitCnt - 5'd1;
                    if (r_bitCnt == 5'd1) begin
                        w_escWidthNext = w_shiftIn[4:0];
                        w_remNext      = '0;
                        if (w_shiftIn[4:0] > 5'd16) begin
                            w_stateNext = ST_ERROR;
                        end else if (w_shiftIn[4:0] == 5'd0) begin
                            w_residualNext = '0;
                            w_stateNext    = ST_EMIT;
                        end else begin
                            w_bitCntNext = w_shiftIn[4:0];
                            w_stateNext  = ST_ESC_RAW;
                        end
                    end
                end
            end

            ST_ESC_RAW: begin
                if (w_bitValid) begin
                    w_remNext    = w_shiftIn;
                    w_bitCntNext = r_bitCnt - 5'd1;
                    if (r_bitCnt == 5'd1) begin
                        w_residualNext = w_rawValue;
                        w_stateNext    = ST_EMIT;
                    end
                end
            end
`endif

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to idle with zeroed outputs.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_rem       <= '0;
            r_bitCnt    <= '0;
            r_count     <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_residual  <= '0;
            r_totalBits <= '0;
            r_done      <= 1'b0;
`ifdef RICE_ESCAPE_EN
            r_escWidth  <= '0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_q         <= w_qNext;
            r_rem       <= w_remNext;
            r_bitCnt    <= w_bitCntNext;
            r_count     <= w_countNext;
            r_n         <= w_nNext;
            r_k         <= w_kNext;
            r_residual  <= w_residualNext;
            r_totalBits <= w_totalBitsNext;
            r_done      <= w_doneNext;
`ifdef RICE_ESCAPE_EN
            r_escWidth  <= w_escWidthNext;
`endif
        end
    end

endmodule

// File: tb/tb_rice_residual_decoder.sv
// tb_rice_residual_decoder: directed vectors for the Rice residual decoder (MAX_QUOTIENT=20).
module tb_rice_residual_decoder;

    logic        iClock;
    logic        iResetN;
    logic        iStart;
    logic [15:0] iNSamples;
    logic [3:0]  iRiceParam;
    logic [15:0] iData;
    logic        iDataValid;
    logic        oDataReady;
    logic [15:0] oResidual;
    logic        oValid;
    logic        iReady;
    logic [31:0] oTotalBits;
    logic        oBusy;
    logic        oDone;
    logic        oError;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              noReset;
        logic [3:0]        k;
        logic [15:0]       n;
        int                nWords;
        logic [1:0][15:0]  words;
        logic [3:0][15:0]  res;
        logic [31:0]       totalBits;
        int                stallCycles;
        logic [31:0]       stallBits;
        int                gapBefore;
        int                gapCycles;
    } vec_t;

    vec_t vecs [6];

    rice_residual_decoder #(
        .MAX_QUOTIENT (20)
    ) dut (
        .iClock     (iClock),
        .iResetN    (iResetN),
        .iStart     (iStart),
        .iNSamples  (iNSamples),
        .iRiceParam (iRiceParam),
        .iData      (iData),
        .iDataValid (iDataValid),
        .oDataReady (oDataReady),
        .oResidual  (oResidual),
        .oValid     (oValid),
        .iReady     (iReady),
        .oTotalBits (oTotalBits),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oError     (oError)
    );

    // 100 MHz free-running clock.
    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    function automatic vec_t mk(input logic noRst, input logic [3:0] k, input logic [15:0] n,
                                input int nw, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3,
                                input logic [31:0] bits, input int stallC,
                                input logic [31:0] stallB, input int gapB, input int gapC);
        vec_t v;
        v.noReset     = noRst;
        v.k           = k;
        v.n           = n;
        v.nWords      = nw;
        v.words[0]    = w0;
        v.words[1]    = w1;
        v.res[0]      = r0;
        v.res[1]      = r1;
        v.res[2]      = r2;
        v.res[3]      = r3;
        v.totalBits   = bits;
        v.stallCycles = stallC;
        v.stallBits   = stallB;
        v.gapBefore   = gapB;
        v.gapCycles   = gapC;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        iResetN    = 1'b0;
        iStart     = 1'b0;
        iDataValid = 1'b0;
        iData      = '0;
        iReady     = 1'b1;
        repeat (2) @(negedge iClock);
        iResetN = 1'b1;
    endtask

    task automatic startPartition(input logic [3:0] k, input logic [15:0] n);
        @(negedge iClock);
        iStart     = 1'b1;
        iNSamples  = n;
        iRiceParam = k;
        @(negedge iClock);
        iStart = 1'b0;
    endtask

    // Runs one table vector: feeds words on demand, optionally stalls or withholds data, checks results.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   widx = 0;
        int   ridx = 0;
        int   stall = 0;
        int   gap = 0;
        int   cyc = 0;
        logic expectDone = 1'b0;
        logic finished = 1'b0;
        if (!v.noReset) doReset();
        iDataValid = 1'b0;
        iReady     = 1'b1;
        startPartition(v.k, v.n);
        checkOutput({tag, " busy"}, 32'(oBusy), 32'd1);
        while (!finished && cyc < 300) begin
            if (expectDone) begin
                checkOutput({tag, " done"}, 32'(oDone), 32'd1);
                checkOutput({tag, " busy low"}, 32'(oBusy), 32'd0);
                checkOutput({tag, " bits"}, oTotalBits, v.totalBits);
                finished = 1'b1;
            end else begin
                if (oDone) checkOutput({tag, " early done"}, 32'(oDone), 32'd0);
                iReady = 1'b1;
                if (oValid) begin
                    if (ridx == 0 && stall < v.stallCycles) begin
                        iReady = 1'b0;
                        checkOutput({tag, " stalled residual"}, 32'(oResidual), 32'(v.res[0]));
                        checkOutput({tag, " stalled ready"}, 32'(oDataReady), 32'd0);
                        checkOutput({tag, " stalled bits"}, oTotalBits, v.stallBits);
                        stall++;
                    end else begin
                        checkOutput($sformatf("%s residual%0d", tag, ridx), 32'(oResidual),
                                    32'(v.res[ridx]));
                        ridx++;
                        if (ridx == int'(v.n)) expectDone = 1'b1;
                    end
                end
                if (widx == v.gapBefore && gap < v.gapCycles) begin
                    iDataValid = 1'b0;
                    if (oDataReady) gap++;
                end else if (widx < v.nWords) begin
                    iDataValid = 1'b1;
                    iData      = v.words[widx];
                    if (oDataReady) widx++;
                end else begin
                    iDataValid = 1'b0;
                end
                @(negedge iClock);
                cyc++;
            end
        end
        iDataValid = 1'b0;
        checkOutput({tag, " finished"}, 32'(finished), 32'd1);
        checkOutput({tag, " count"}, 32'(ridx), 32'(v.n));
    endtask

    task automatic checkEmptyPartition(input logic [3:0] k, input string tag);
        doReset();
        startPartition(k, 16'd0);
        checkOutput({tag, " done"}, 32'(oDone), 32'd1);
        checkOutput({tag, " busy"}, 32'(oBusy), 32'd0);
        checkOutput({tag, " ready"}, 32'(oDataReady), 32'd0);
        checkOutput({tag, " bits"}, oTotalBits, 32'd0);
        @(negedge iClock);
        checkOutput({tag, " done pulse"}, 32'(oDone), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic sawValid;
        iResetN    = 1'b0;
        iStart     = 1'b0;
        iNSamples  = '0;
        iRiceParam = '0;
        iData      = '0;
        iDataValid = 1'b0;
        iReady     = 1'b1;

        // residuals: -1=FFFF, -2=FFFE, -4=FFFC, +1000=03E8, -1000=FC18
        vecs[0] = mk(1'b0, 4'd0, 16'd4, 1, 16'hA440, 16'h0000,
                     16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 32'd10, 0, 32'd0, 0, 0);
        vecs[1] = mk(1'b0, 4'd2, 16'd2, 1, 16'h6700, 16'h0000,
                     16'h0003, 16'hFFFC, 16'h0000, 16'h0000, 32'd8, 0, 32'd0, 0, 0);
        vecs[2] = mk(1'b0, 4'd2, 16'd2, 1, 16'h6700, 16'h0000,
                     16'h0003, 16'hFFFC, 16'h0000, 16'h0000, 32'd8, 5, 32'd4, 0, 0);
        vecs[3] = mk(1'b0, 4'd14, 16'd2, 2, 16'h8FA1, 16'h1F3C,
                     16'h03E8, 16'hFC18, 16'h0000, 16'h0000, 32'd30, 0, 32'd0, 1, 3);
        vecs[4] = mk(1'b0, 4'd0, 16'd2, 1, 16'hA440, 16'h0000,
                     16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 32'd3, 0, 32'd0, 0, 0);
        vecs[5] = mk(1'b1, 4'd0, 16'd2, 0, 16'h0000, 16'h0000,
                     16'h0001, 16'hFFFE, 16'h0000, 16'h0000, 32'd7, 0, 32'd0, 0, 0);

        doReset();
        @(negedge iClock);
        checkOutput("reset ready", 32'(oDataReady), 32'd0);
        checkOutput("reset valid", 32'(oValid), 32'd0);
        checkOutput("reset done", 32'(oDone), 32'd0);
        checkOutput("reset busy", 32'(oBusy), 32'd0);
        checkOutput("reset error", 32'(oError), 32'd0);
        checkOutput("reset residual", 32'(oResidual), 32'd0);
        checkOutput("reset bits", oTotalBits, 32'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        checkEmptyPartition(4'd0, "n0");

        // Quotient overflow: 21 zeros with MAX_QUOTIENT=20, then a restart must clear and flush.
        doReset();
        startPartition(4'd0, 16'd1);
        cyc = 0;
        sawValid = 1'b0;
        while (!oError && cyc < 100) begin
            if (oValid) sawValid = 1'b1;
            iDataValid = 1'b1;
            iData      = 16'h0000;
            @(negedge iClock);
            cyc++;
        end
        iDataValid = 1'b0;
        checkOutput("err flag", 32'(oError), 32'd1);
        checkOutput("err no valid", 32'(sawValid), 32'd0);
        checkOutput("err bits", oTotalBits, 32'd21);
        checkOutput("err busy", 32'(oBusy), 32'd0);
        checkOutput("err ready", 32'(oDataReady), 32'd0);
        @(negedge iClock);
        checkOutput("err sticky", 32'(oError), 32'd1);
        startPartition(4'd0, 16'd1);
        checkOutput("restart error", 32'(oError), 32'd0);
        checkOutput("restart busy", 32'(oBusy), 32'd1);
        checkOutput("restart bits", oTotalBits, 32'd0);
        checkOutput("restart flushed", 32'(oDataReady), 32'd1);
        iDataValid = 1'b1;
        iData      = 16'h8000;
        @(negedge iClock);
        iDataValid = 1'b0;
        cyc = 0;
        while (!oValid && cyc < 50) begin
            @(negedge iClock);
            cyc++;
        end
        checkOutput("restart valid", 32'(oValid), 32'd1);
        checkOutput("restart residual", 32'(oResidual), 32'd0);
        @(negedge iClock);
        checkOutput("restart done", 32'(oDone), 32'd1);
        checkOutput("restart total", oTotalBits, 32'd1);

`ifdef RICE_ESCAPE_EN
        applyStimulus(mk(1'b0, 4'd15, 16'd2, 1, 16'h27B8, 16'h0000,
                         16'hFFFF, 16'h0007, 16'h0000, 16'h0000, 32'd13, 0, 32'd0, 0, 0), "esc");
        checkEmptyPartition(4'd15, "esc n0");
`else
        doReset();
        startPartition(4'd15, 16'd2);
        checkOutput("k15 error", 32'(oError), 32'd1);
        checkOutput("k15 busy", 32'(oBusy), 32'd0);
        checkOutput("k15 ready", 32'(oDataReady), 32'd0);
`endif

        // Reset mid-partition clears everything at once and empties the buffer.
        doReset();
        startPartition(4'd2, 16'd2);
        iDataValid = 1'b1;
        iData      = 16'h6700;
        @(negedge iClock);
        iDataValid = 1'b0;
        repeat (3) @(negedge iClock);
        checkOutput("pre-reset busy", 32'(oBusy), 32'd1);
        iResetN = 1'b0;
        #1;
        checkOutput("mid reset busy", 32'(oBusy), 32'd0);
        checkOutput("mid reset bits", oTotalBits, 32'd0);
        checkOutput("mid reset valid", 32'(oValid), 32'd0);
        @(negedge iClock);
        iResetN = 1'b1;
        startPartition(4'd0, 16'd1);
        checkOutput("post reset empty", 32'(oDataReady), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
